branch_hazard_ctrl: RTL and testbench

BRANCH_HAZARD_CTRL -- requirements
Module: branch_hazard_ctrl

---
 rtl/branch_hazard_ctrl_if.sv | 25 ++
 rtl/branch_hazard_ctrl.sv | 67 ++++++
 tb/tb_branch_hazard_ctrl.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/branch_hazard_ctrl_if.sv
// branch_hazard_ctrl_if: D-stage operand/producer info in, stall/flush/forward controls out
interface branch_hazard_ctrl_if;
  logic        D_valid;
  logic [4:0]  D_rs;
  logic [4:0]  D_rt;
  logic [1:0]  D_tuse_rs;
  logic [1:0]  D_tuse_rt;
  logic [4:0]  D_dst;
  logic [1:0]  D_tnew;
  logic        D_cleardb;
  logic        stall;
  logic        E_bubble;
  logic        FD_flush;
  logic [1:0]  fwd_rs_sel;
  logic [1:0]  fwd_rt_sel;
  logic [15:0] stall_cnt;
  modport master (
    output D_valid, D_rs, D_rt, D_tuse_rs, D_tuse_rt, D_dst, D_tnew, D_cleardb,
    input  stall, E_bubble, FD_flush, fwd_rs_sel, fwd_rt_sel, stall_cnt
  );
  modport slave (
    input  D_valid, D_rs, D_rt, D_tuse_rs, D_tuse_rt, D_dst, D_tnew, D_cleardb,
    output stall, E_bubble, FD_flush, fwd_rs_sel, fwd_rt_sel, stall_cnt
  );
endinterface

// File: rtl/branch_hazard_ctrl.sv
// branch_hazard_ctrl: tuse/tnew scoreboard driving D-stage stall, bubble, annul and compare forwarding
module branch_hazard_ctrl (
  input logic                clk,
  input logic                reset,
  branch_hazard_ctrl_if.slave bus
);
  typedef struct packed {
    logic       v;
    logic [4:0] dst;
    logic [1:0] tnew;
  } ent_t;
  ent_t        e_q, m_q, w_q, e_d, m_d, w_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  rs_res, rt_res;
  logic        stall;
  logic        live;
  // {hazard, stage code if forwardable}; the youngest matching entry decides
  function automatic logic [2:0] resolve(input logic [4:0] r, input logic [1:0] tuse,
                                         input ent_t e, input ent_t m, input ent_t w);
    logic       hit_e, hit_m, hit_w;
    logic [1:0] code, tn;
    hit_e = e.v && e.dst == r;
    hit_m = m.v && m.dst == r;
    hit_w = w.v && w.dst == r;
    code  = hit_e ? 2'd1 : hit_m ? 2'd2 : hit_w ? 2'd3 : 2'd0;
    tn    = hit_e ? e.tnew : hit_m ? m.tnew : w.tnew;
    if (r == 5'd0 || tuse == 2'd3 || code == 2'd0) return 3'b000;
    return {tn > tuse, tn == 2'd0 ? code : 2'd0};
  endfunction
  function automatic logic [1:0] dec(input logic [1:0] t);
    return t == 2'd0 ? 2'd0 : t - 2'd1;
  endfunction
  // hazard detection and forwarding selects, forced quiet while reset is held
  always_comb begin
    rs_res         = resolve(bus.D_rs, bus.D_tuse_rs, e_q, m_q, w_q);
    rt_res         = resolve(bus.D_rt, bus.D_tuse_rt, e_q, m_q, w_q);
    live           = ~reset & bus.D_valid;
    stall          = live & (rs_res[2] | rt_res[2]);
    bus.stall      = stall;
    bus.E_bubble   = stall;
    bus.FD_flush   = ~reset & bus.D_cleardb & ~stall;
    bus.fwd_rs_sel = live ? rs_res[1:0] : 2'd0;
    bus.fwd_rt_sel = live ? rt_res[1:0] : 2'd0;
    bus.stall_cnt  = cnt_q;
  end
  // scoreboard advance: E takes D or a bubble, older entries age toward forwardable
  always_comb begin
    e_d   = stall ? '0 : {bus.D_valid, bus.D_dst, bus.D_tnew};
    m_d   = {e_q.v, e_q.dst, dec(e_q.tnew)};
    w_d   = {m_q.v, m_q.dst, dec(m_q.tnew)};
    cnt_d = (stall && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
  end
  // state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_q   <= '0;
      m_q   <= '0;
      w_q   <= '0;
      cnt_q <= '0;
    end else begin
      e_q   <= e_d;
      m_q   <= m_d;
      w_q   <= w_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// tb_branch_hazard_ctrl: directed and random checks against an issue-history reference model
module tb_branch_hazard_ctrl;
  logic clk;
  logic reset;
  branch_hazard_ctrl_if bus ();
  branch_hazard_ctrl dut (.clk(clk), .reset(reset), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  int n_asrt = 0;
  int n_fail = 0;
  // model: the last three issued instructions with their issue-time tnew; index = cycles since issue - 1
  bit pv[3];
  int pd[3];
  int pt[3];
  int ecnt;
  logic last_stall, last_flush;
  logic [1:0] last_rs, last_rt;
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic clear_model();
    for (int k = 0; k < 3; k++) begin
      pv[k] = 0;
      pd[k] = 0;
      pt[k] = 0;
    end
    ecnt = 0;
  endtask
  task automatic mdl(input int r, input int tuse, output bit hz, output int sel);
    int rem;
    hz = 0;
    sel = 0;
    if (r == 0 || tuse == 3) return;
    for (int k = 0; k < 3; k++) begin
      if (pv[k] && pd[k] == r) begin
        rem = pt[k] - k;
        if (rem < 0) rem = 0;
        hz = rem > tuse;
        sel = (rem == 0) ? k + 1 : 0;
        return;
      end
    end
  endtask
  task automatic issue(input bit v, input int rs, input int rt, input int tr, input int tt,
                       input int dst, input int tn, input bit cdb);
    bit hs, ht, es;
    int ss, st;
    bus.D_valid   = v;
    bus.D_rs      = rs[4:0];
    bus.D_rt      = rt[4:0];
    bus.D_tuse_rs = tr[1:0];
    bus.D_tuse_rt = tt[1:0];
    bus.D_dst     = dst[4:0];
    bus.D_tnew    = tn[1:0];
    bus.D_cleardb = cdb;
    mdl(rs, tr, hs, ss);
    mdl(rt, tt, ht, st);
    es = v & (hs | ht);
    @(negedge clk);
    chk("stall", 16'(bus.stall), 16'(es));
    chk("e_bubble", 16'(bus.E_bubble), 16'(es));
    chk("fd_flush", 16'(bus.FD_flush), 16'(cdb & !es));
    chk("fwd_rs_sel", 16'(bus.fwd_rs_sel), v ? 16'(ss) : 16'd0);
    chk("fwd_rt_sel", 16'(bus.fwd_rt_sel), v ? 16'(st) : 16'd0);
    chk("stall_cnt", bus.stall_cnt, 16'(ecnt));
    last_stall = bus.stall;
    last_flush = bus.FD_flush;
    last_rs    = bus.fwd_rs_sel;
    last_rt    = bus.fwd_rt_sel;
    @(posedge clk);
    pv[2] = pv[1]; pd[2] = pd[1]; pt[2] = pt[1];
    pv[1] = pv[0]; pd[1] = pd[0]; pt[1] = pt[0];
    pv[0] = v && !es; pd[0] = es ? 0 : dst; pt[0] = es ? 0 : tn;
    if (es && ecnt < 65535) ecnt++;
    #1;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    bus.D_valid = 0; bus.D_rs = 0; bus.D_rt = 0; bus.D_tuse_rs = 0; bus.D_tuse_rt = 0;
    bus.D_dst = 0; bus.D_tnew = 0; bus.D_cleardb = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_stall", 16'(bus.stall), 16'd0);
    chk("rst_flush", 16'(bus.FD_flush), 16'd0);
    chk("rst_cnt", bus.stall_cnt, 16'd0);
    clear_model();
    reset = 1'b0;
    bus.D_cleardb = 1'b0;
  endtask
  initial begin
    reset = 1'b1;
    clear_model();
    do_reset();
    // load r8 then beq r8,r9: two stalls, then forward from W
    issue(1, 0, 0, 3, 3, 8, 2, 0);
    issue(1, 8, 9, 0, 0, 0, 0, 0); chk("ld_beq_c1", 16'(last_stall), 16'd1);
    issue(1, 8, 9, 0, 0, 0, 0, 0); chk("ld_beq_c2", 16'(last_stall), 16'd1);
    issue(1, 8, 9, 0, 0, 0, 0, 0); chk("ld_beq_c3", 16'(last_stall), 16'd0);
    chk("ld_beq_fwd", 16'(last_rs), 16'd3);
    chk("ld_beq_cnt", bus.stall_cnt, 16'd2);
    // ALU r5 then beq r5,r0: one stall, then forward from M
    do_reset();
    issue(1, 0, 0, 3, 3, 5, 1, 0);
    issue(1, 5, 0, 0, 0, 0, 0, 0); chk("alu_c1", 16'(last_stall), 16'd1);
    chk("alu_rt0_c1", 16'(last_rt), 16'd0);
    issue(1, 5, 0, 0, 0, 0, 0, 0); chk("alu_c2", 16'(last_stall), 16'd0);
    chk("alu_fwd", 16'(last_rs), 16'd2);
    chk("alu_rt0_c2", 16'(last_rt), 16'd0);
    // link r31 then beq r31,r4: forward from E at once
    do_reset();
    issue(1, 0, 0, 3, 3, 31, 0, 0);
    issue(1, 31, 4, 0, 0, 0, 0, 0); chk("link_stall", 16'(last_stall), 16'd0);
    chk("link_fwd", 16'(last_rs), 16'd1);
    // ALU r7 then load r7: the younger load governs
    do_reset();
    issue(1, 0, 0, 3, 3, 7, 1, 0);
    issue(1, 0, 0, 3, 3, 7, 2, 0);
    issue(1, 7, 0, 0, 0, 0, 0, 0); chk("dup_c1", 16'(last_stall), 16'd1);
    issue(1, 7, 0, 0, 0, 0, 0, 0); chk("dup_c2", 16'(last_stall), 16'd1);
    issue(1, 7, 0, 0, 0, 0, 0, 0); chk("dup_c3", 16'(last_stall), 16'd0);
    chk("dup_fwd", 16'(last_rs), 16'd3);
    // annul without hazard flushes for one cycle only
    do_reset();
    issue(1, 3, 4, 0, 0, 0, 0, 1); chk("annul_flush", 16'(last_flush), 16'd1);
    issue(1, 3, 4, 0, 0, 0, 0, 0); chk("annul_once", 16'(last_flush), 16'd0);
    // annul held under a stall waits for release
    issue(1, 0, 0, 3, 3, 8, 2, 0);
    issue(1, 8, 9, 0, 0, 0, 0, 1); chk("annul_stall1", 16'(last_flush), 16'd0);
    issue(1, 8, 9, 0, 0, 0, 0, 1); chk("annul_stall2", 16'(last_flush), 16'd0);
    issue(1, 8, 9, 0, 0, 0, 0, 1); chk("annul_release", 16'(last_flush), 16'd1);
    // register 0 never hazards nor forwards
    issue(1, 0, 0, 3, 3, 0, 2, 0);
    issue(1, 0, 0, 0, 0, 0, 0, 0); chk("r0_stall", 16'(last_stall), 16'd0);
    chk("r0_fwd", 16'(last_rs), 16'd0);
    // reset pulsed mid-stall drops the stall without a clock edge
    do_reset();
    issue(1, 0, 0, 3, 3, 8, 2, 0);
    issue(1, 8, 9, 0, 0, 0, 0, 0);
    #2;
    chk("pre_rst_stall", 16'(bus.stall), 16'd1);
    reset = 1'b1;
    #1;
    chk("async_stall", 16'(bus.stall), 16'd0);
    chk("async_bubble", 16'(bus.E_bubble), 16'd0);
    chk("async_rs", 16'(bus.fwd_rs_sel), 16'd0);
    chk("async_rt", 16'(bus.fwd_rt_sel), 16'd0);
    chk("async_cnt", bus.stall_cnt, 16'd0);
    @(posedge clk);
    #1;
    clear_model();
    reset = 1'b0;
    issue(1, 8, 9, 0, 0, 0, 0, 0); chk("post_rst_beq", 16'(last_stall), 16'd0);
    // random traffic over a small register set to provoke hazards
    for (int i = 0; i < 500; i++) begin
      issue($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
            $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 7),
            $urandom_range(0, 2), $urandom_range(0, 3) == 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
